mem4x16_arbiter: RTL

- Round-robin arbiter and access sequencer that shares one 4-word x 16-bit register memory between two requesters, A and B.
- Sits between the requesters and the memory array (address decode, JK-cell words, output mux).
- Drives the memory's address, rw and enable lines.
- Returns read data and completion strobes to the requester it served.

---
 rtl/mem4x16_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem4x16_arbiter.sv
// Round-robin arbiter that sequences requesters A and B onto one shared 4x16 register memory.
// Define MEM_ARB_PROTECT_EN to add per-word write protection (wp input, err output).
module mem4x16_arbiter #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_rw,
    input  logic [AW-1:0] a_add,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_rw,
    input  logic [AW-1:0] b_add,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_done,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_add,
    output logic          mem_rw,
    output logic          mem_en,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
`ifdef MEM_ARB_PROTECT_EN
    ,
    input  logic [2**AW-1:0] wp,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 1 = B owns the current transaction
    logic          prio_q, prio_d;     // 1 = B wins a tie
    logic          rw_q, rw_d;
    logic [AW-1:0] add_q, add_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          blocked;
    logic          win_b;

`ifdef MEM_ARB_PROTECT_EN
    logic blk_q, blk_d;
    assign blocked = rw_q & wp[add_q];
`else
    assign blocked = 1'b0;
`endif

    assign win_b = b_req & (~a_req | prio_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        rw_d      = rw_q;
        add_d     = add_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        a_done    = 1'b0;
        b_done    = 1'b0;
        mem_en    = 1'b0;
`ifdef MEM_ARB_PROTECT_EN
        blk_d     = blk_q;
        err       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (a_req | b_req) begin
                    owner_d = win_b;
                    rw_d    = win_b ? b_rw    : a_rw;
                    add_d   = win_b ? b_add   : a_add;
                    wdata_d = win_b ? b_wdata : a_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                a_gnt  = ~owner_q;
                b_gnt  = owner_q;
                mem_en = ~blocked;
                // mem_dout is combinational from mem_add, so it is valid within this cycle
                if (!rw_q) begin
                    if (owner_q) b_rdata_d = mem_dout;
                    else         a_rdata_d = mem_dout;
                end
`ifdef MEM_ARB_PROTECT_EN
                blk_d = blocked;
`endif
                state_d = COMPLETE;
            end
            COMPLETE: begin
                a_done  = ~owner_q;
                b_done  = owner_q;
`ifdef MEM_ARB_PROTECT_EN
                err     = blk_q;
`endif
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            rw_q      <= 1'b0;
            add_q     <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef MEM_ARB_PROTECT_EN
            blk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            rw_q      <= rw_d;
            add_q     <= add_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifdef MEM_ARB_PROTECT_EN
            blk_q     <= blk_d;
`endif
        end
    end

    // Latched request fields double as the memory bus, so they hold between accesses
    assign mem_add = add_q;
    assign mem_rw  = rw_q;
    assign mem_din = wdata_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = (state_q != IDLE);

endmodule
